// File: rtl/uart_tx_drain.sv
// Serial transmitter draining a show-ahead tx fifo.
// Each popped byte goes out as one start bit, LSB-first data bits and 1 or 2 stop bits.
module uart_tx_drain #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_drain: SYS_CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_tx_drain: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_idx;

    // Gated by reset so a held reset never pops a byte that would then be lost.
    assign fifo_rd_en = (state == IDLE) && !fifo_empty && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_rd_en) begin
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        shift    <= fifo_rd_data;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                        shift    <= shift >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
